multicycle_subtractor: RTL and testbench
========================================

MULTICYCLE_SUBTRACTOR -- requirements
Module: multicycle_subtractor

Interface
REQ-001 Parameter WIDTH, default 16, sets the operand and result width in bits.
REQ-002 Parameter DIGIT, default 4, sets the bits subtracted per clock cycle; the digit count NDIG = WIDTH/DIGIT.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operands and Bin are valid.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 A  input  WIDTH  minuend.
REQ-008 B  input  WIDTH  subtrahend.
REQ-009 Bin  input  1  borrow-in.
REQ-010 out_valid  output  1  Diff/Borr (and Ovf) hold a completed result.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 Diff  output  WIDTH  A - B - Bin, modulo 2^WIDTH.
REQ-013 Borr  output  1  borrow-out of the MSB digit (1 when unsigned A < B + Bin).
REQ-014 Ovf  output  1  signed overflow; present only when SUB_OVERFLOW_EN is defined.

Function
REQ-015 FSM states SHALL be IDLE, CALC and DONE.
REQ-016 in_ready SHALL equal (state==IDLE) && !rst; out_valid SHALL equal (state==DONE).
REQ-017 Accept SHALL occur on a rising edge with in_valid && in_ready:
  - latch A and B;
  - borrow register <= Bin;
  - digit counter <= 0;
  - state <= CALC.
REQ-018 In CALC, each edge SHALL:
  - compute digit k = counter: A[k] - B[k] - borrow;
  - write the DIGIT-bit result into Diff[k*DIGIT +: DIGIT];
  - update the borrow register with that digit's borrow-out;
  - increment the counter.
REQ-019 The edge that processes digit NDIG-1 SHALL move the state to DONE, so out_valid rises exactly NDIG edges after the accepting edge.
REQ-020 Borr SHALL equal the final borrow register value while in DONE.
REQ-021 In DONE, Diff, Borr and Ovf SHALL hold stable until an edge with out_ready=1, which SHALL move the state to IDLE; no new accept in that same edge.
REQ-022 in_valid, A, B and Bin SHALL be ignored outside IDLE.
REQ-023 out_ready SHALL be ignored outside DONE.
REQ-024 Throughput SHALL be at most one operation per NDIG+2 cycles.

Reset
REQ-025 An edge with rst=1 SHALL, from any state including mid-CALC, force state=IDLE, and clear to 0 the counter, the borrow register, Diff, Borr and Ovf.
REQ-026 During reset, out_valid=0 and in_ready=0; in_ready=1 in the first cycle after rst deasserts.

Configuration
REQ-027 With SUB_OVERFLOW_EN defined:
  - the Ovf port SHALL exist;
  - in DONE, Ovf = (A[msb]!=B[msb]) && (Diff[msb]!=A[msb]), using the latched operands.
REQ-028 Without SUB_OVERFLOW_EN, the Ovf port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-029 The shared package sub_pkg SHALL hold the FSM state encoding (IDLE=2'd0, CALC=2'd1, DONE=2'd2) and the default WIDTH/DIGIT constants.
REQ-030 Elaboration SHALL fail if WIDTH % DIGIT != 0 or DIGIT < 1.
REQ-031 Per-digit arithmetic SHALL be a combinational sub-module digit_subtractor:
  - parameter DIGIT;
  - inputs a, b, bin;
  - outputs diff, bout;
  - built as a chain of half/full subtractor cells.

Verification
REQ-032 WIDTH=16, DIGIT=4; A=0x1234, B=0x0234, Bin=0 -> Diff=0x1000, Borr=0, out_valid exactly 4 edges after accept.
REQ-033 A=0x0000, B=0x0001, Bin=0 -> Diff=0xFFFF, Borr=1; the borrow ripples through all 4 digits.
REQ-034 With SUB_OVERFLOW_EN: A=0x8000, B=0x0001, Bin=0 -> Diff=0x7FFF, Borr=0, Ovf=1; A=0x0005, B=0x0003 -> Ovf=0.
REQ-035 Result held with out_ready=0 for 10 cycles:
  - Diff/Borr stable and in_ready=0 throughout;
  - a new in_valid pulse is ignored;
  - out_ready=1 -> IDLE next cycle.
REQ-036 rst pulsed in CALC with counter=2 -> next cycle state IDLE, Diff=0, Borr=0, out_valid=0; in_ready=1 after deassert, and a fresh operation completes correctly.
REQ-037 DIGIT=1 and DIGIT=16; A=5, B=3, Bin=1 -> Diff=1, Borr=0, latency 16 and 1 edges respectively.

Source files
------------

// File: rtl/sub_pkg.sv
// Shared constants for the multi-cycle subtractor: FSM encoding and default geometry.
package sub_pkg;
    localparam int DEF_WIDTH = 16;
    localparam int DEF_DIGIT = 4;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // A digit counter is at least one bit wide, even for a single-digit build.
    function automatic int cnt_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/digit_subtractor.sv
// Combinational DIGIT-bit subtractor: a - b - bin, built as a ripple of full
// subtractor cells, each made from two half subtractors.
module digit_subtractor #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             bin,
    output logic [DIGIT-1:0] diff,
    output logic             bout
);
    logic [DIGIT:0] bw;

    assign bw[0] = bin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_cell
        logic hd, hb1, hb2;
        assign hd       = a[i] ^ b[i];
        assign hb1      = ~a[i] & b[i];
        assign diff[i]  = hd ^ bw[i];
        assign hb2      = ~hd & bw[i];
        assign bw[i+1]  = hb1 | hb2;
    end

    assign bout = bw[DIGIT];
endmodule

// File: rtl/multicycle_subtractor.sv
// Digit-serial subtractor: one DIGIT-wide slice per clock, LSB digit first.
// Define SUB_OVERFLOW_EN to add the signed-overflow output Ovf.
module multicycle_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DIGIT = DEF_DIGIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Diff,
    output logic             Borr
`ifdef SUB_OVERFLOW_EN
    ,
    output logic             Ovf
`endif
);
    localparam int NDIG = (DIGIT > 0) ? WIDTH / DIGIT : 1;
    localparam int CW   = cnt_bits(NDIG);
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    if (DIGIT < 1) begin : g_bad_digit
        $error("multicycle_subtractor: DIGIT must be >= 1");
    end else if (WIDTH % DIGIT != 0) begin : g_bad_width
        $error("multicycle_subtractor: WIDTH must be a multiple of DIGIT");
    end

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_q, b_q, diff_q;
    logic             brw;
    logic [DIGIT-1:0] a_dig, b_dig, d_dig;
    logic             d_bout;

    assign a_dig = a_q[DIGIT*int'(cnt) +: DIGIT];
    assign b_dig = b_q[DIGIT*int'(cnt) +: DIGIT];

    digit_subtractor #(.DIGIT(DIGIT)) u_dig (
        .a    (a_dig),
        .b    (b_dig),
        .bin  (brw),
        .diff (d_dig),
        .bout (d_bout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            brw    <= 1'b0;
            diff_q <= '0;
            a_q    <= '0;
            b_q    <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_q   <= A;
                    b_q   <= B;
                    brw   <= Bin;
                    cnt   <= '0;
                    state <= CALC;
                end
                CALC: begin
                    diff_q[DIGIT*int'(cnt) +: DIGIT] <= d_dig;
                    brw <= d_bout;
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) state <= DONE;
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign Diff      = diff_q;
    // The borrow register holds the MSB digit's borrow-out once CALC finishes.
    assign Borr      = brw;

`ifdef SUB_OVERFLOW_EN
    assign Ovf = (state == DONE) && (a_q[WIDTH-1] != b_q[WIDTH-1])
                 && (diff_q[WIDTH-1] != a_q[WIDTH-1]);
`endif
endmodule

// File: tb/tb_multicycle_subtractor.sv
// Self-checking bench for multicycle_subtractor: vector table + scoreboard,
// handshake hold, mid-operation reset and DIGIT=1/16 latency sequences.
module tb_multicycle_subtractor;
    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        bin;
        logic [15:0] diff;
        logic        borr;
        logic        ovf;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
    logic [15:0] A = '0, B = '0, Diff;
    logic        Bin = 1'b0, Borr;

    logic        x_valid = 1'b0, x_oready = 1'b0, x_bin = 1'b0;
    logic [15:0] x_a = '0, x_b = '0;
    logic        r1_ready, r1_ovalid, r1_borr, r16_ready, r16_ovalid, r16_borr;
    logic [15:0] r1_diff, r16_diff;
`ifdef SUB_OVERFLOW_EN
    logic        Ovf, r1_ovf, r16_ovf;
`endif

    int checks = 0;
    int failures = 0;
    vec_t sb_q[$];
    vec_t tbl[8];

    always #5 clk = ~clk;

    multicycle_subtractor #(.WIDTH(16), .DIGIT(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Bin(Bin), .out_valid(out_valid), .out_ready(out_ready),
        .Diff(Diff), .Borr(Borr)
`ifdef SUB_OVERFLOW_EN
        , .Ovf(Ovf)
`endif
    );

    multicycle_subtractor #(.WIDTH(16), .DIGIT(1)) u_d1 (
        .clk(clk), .rst(rst), .in_valid(x_valid), .in_ready(r1_ready),
        .A(x_a), .B(x_b), .Bin(x_bin), .out_valid(r1_ovalid), .out_ready(x_oready),
        .Diff(r1_diff), .Borr(r1_borr)
`ifdef SUB_OVERFLOW_EN
        , .Ovf(r1_ovf)
`endif
    );

    multicycle_subtractor #(.WIDTH(16), .DIGIT(16)) u_d16 (
        .clk(clk), .rst(rst), .in_valid(x_valid), .in_ready(r16_ready),
        .A(x_a), .B(x_b), .Bin(x_bin), .out_valid(r16_ovalid), .out_ready(x_oready),
        .Diff(r16_diff), .Borr(r16_borr)
`ifdef SUB_OVERFLOW_EN
        , .Ovf(r16_ovf)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] a, input logic [15:0] b, input logic bin);
        vec_t v;
        logic [16:0] r;
        r = {1'b0, a} - {1'b0, b} - 17'(bin);
        v.a = a; v.b = b; v.bin = bin;
        v.diff = r[15:0];
        v.borr = r[16];
        v.ovf  = (a[15] != b[15]) && (r[15] != a[15]);
        return v;
    endfunction

    task automatic start_op(input vec_t v);
        @(negedge clk);
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        A = v.a; B = v.b; Bin = v.bin; in_valid = 1'b1;
        sb_q.push_back(v);
        @(posedge clk); #1;
        in_valid = 1'b0;
        A = 16'($urandom); B = 16'($urandom); Bin = 1'($urandom);
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic check_result();
        vec_t e;
        if (sb_q.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk("diff", 32'(Diff), 32'(e.diff));
            chk("borr", 32'(Borr), 32'(e.borr));
`ifdef SUB_OVERFLOW_EN
            chk("ovf", 32'(Ovf), 32'(e.ovf));
`endif
        end
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("release_out_valid", 32'(out_valid), 32'd0);
        chk("release_in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic run_op(input vec_t v);
        int lat;
        start_op(v);
        wait_out(lat);
        chk("latency", 32'(lat), 32'd4);
        check_result();
        release_out();
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat, l1, l16;

        tbl[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0};
        tbl[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        tbl[2] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
        tbl[3] = '{16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0};
        tbl[4] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        tbl[5] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
        tbl[6] = mk(16'($urandom), 16'($urandom), 1'($urandom));
        tbl[7] = mk(16'($urandom), 16'($urandom), 1'($urandom));

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_diff", 32'(Diff), 32'd0);
        chk("rst_borr", 32'(Borr), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 8; i++) run_op(tbl[i]);

        // Result held for 10 cycles with an ignored in_valid pulse
        start_op(tbl[0]);
        wait_out(lat);
        chk("hold_latency", 32'(lat), 32'd4);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = (i == 3);
            A = 16'hFFFF; B = 16'h0001; Bin = 1'b1;
            chk("hold_diff", 32'(Diff), 32'h1000);
            chk("hold_borr", 32'(Borr), 32'd0);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_out_valid", 32'(out_valid), 32'd1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        check_result();
        release_out();
        repeat (6) @(posedge clk);
        #1;
        chk("ignored_pulse", 32'(out_valid), 32'd0);

        // Reset after two CALC digits
        start_op(mk(16'hABCD, 16'h1234, 1'b0));
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_diff", 32'(Diff), 32'd0);
        chk("midrst_borr", 32'(Borr), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        void'(sb_q.pop_back());
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_release_ready", 32'(in_ready), 32'd1);
        run_op(mk(16'h4321, 16'h1111, 1'b1));

        // DIGIT=1 and DIGIT=16 instances side by side
        @(negedge clk);
        x_a = 16'd5; x_b = 16'd3; x_bin = 1'b1; x_valid = 1'b1;
        @(posedge clk); #1;
        x_valid = 1'b0;
        l1 = -1; l16 = -1;
        for (int e = 1; e <= 40 && (l1 < 0 || l16 < 0); e++) begin
            @(posedge clk); #1;
            if (r1_ovalid && l1 < 0) l1 = e;
            if (r16_ovalid && l16 < 0) l16 = e;
        end
        chk("d1_latency", 32'(l1), 32'd16);
        chk("d16_latency", 32'(l16), 32'd1);
        chk("d1_diff", 32'(r1_diff), 32'd1);
        chk("d1_borr", 32'(r1_borr), 32'd0);
        chk("d16_diff", 32'(r16_diff), 32'd1);
        chk("d16_borr", 32'(r16_borr), 32'd0);
        @(negedge clk);
        x_oready = 1'b1;
        @(posedge clk); #1;
        x_oready = 1'b0;
        chk("d1_release", 32'(r1_ready), 32'd1);
        chk("d16_release", 32'(r16_ready), 32'd1);

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
